// File: rtl/soc_bus_pkg.sv
// ============================================================================
// soc_bus_pkg : shared encodings and bus widths for the SoC bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package soc_bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] C_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;
endpackage

`default_nettype wire

// File: rtl/soc_bus_arbiter_if.sv
// ============================================================================
// soc_bus_arbiter_if : fetch/load-store requester ports plus the shared slave bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface soc_bus_arbiter_if;
  import soc_bus_pkg::*;

  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [STRB_W-1:0] m1_wstrb;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_gnt;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;

  logic              bus_err;

  // The arbiter is the slave of both core ports and drives the memory bus.
  modport slave (
    input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    input  s_gnt, s_rvalid, s_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    output s_req, s_we, s_addr, s_wdata, s_wstrb, bus_err
  );

  modport master (
    output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    output s_gnt, s_rvalid, s_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    input  s_req, s_we, s_addr, s_wdata, s_wstrb, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/soc_bus_arbiter_sat_counter.sv
// ============================================================================
// bus_sat_counter : counter with synchronous clear that saturates at LIMIT
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_sat_counter #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_clr,
  input  wire logic             i_inc,
  output logic      [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != WIDTH'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

`default_nettype wire

// File: rtl/soc_bus_arbiter.sv
// ============================================================================
// soc_bus_arbiter : two-port bus arbiter with M0 starvation guard and timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int                STARVE_LIM  = 4,
  parameter int                TIMEOUT_CYC = 16,
  parameter logic [DATA_W-1:0] ERR_DATA    = C_ERR_DATA
) (
  input wire logic        clk,
  input wire logic        reset,
  soc_bus_arbiter_if.slave bus
);
  state_t            r_state;
  owner_t            r_owner;
  logic [2:0]        w_starve;
  logic [4:0]        w_tmo;
  logic              w_idle;
  logic              w_any_req;
  logic              w_m1_win;
  logic              w_take;
  logic              w_timeout;
  logic              w_done;
  logic [DATA_W-1:0] w_rdata;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_any_req = bus.m0_req | bus.m1_req;
  assign w_m1_win  = bus.m1_req && !(bus.m0_req && (w_starve == 3'(STARVE_LIM)));
  assign w_take    = w_idle && w_any_req && bus.s_gnt;
  assign w_timeout = !w_idle && !bus.s_rvalid && (w_tmo == 5'(TIMEOUT_CYC - 1));
  assign w_done    = !w_idle && (bus.s_rvalid || w_timeout);
  assign w_rdata   = bus.s_rvalid ? bus.s_rdata : ERR_DATA;

  bus_sat_counter #(.WIDTH(3), .LIMIT(STARVE_LIM)) u_starve (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_take && !w_m1_win),
    .i_inc (w_take && w_m1_win && bus.m0_req),
    .o_cnt (w_starve)
  );

  bus_sat_counter #(.WIDTH(5), .LIMIT(TIMEOUT_CYC - 1)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_take),
    .i_inc (!w_idle && !bus.s_rvalid),
    .o_cnt (w_tmo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_IF;
    end else begin
      case (r_state)
        ST_IDLE: if (w_take) begin
          r_state <= ST_WAIT;
          r_owner <= w_m1_win ? OWN_LSU : OWN_IF;
        end
        ST_WAIT: if (w_done) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, regardless of requester inputs.
  always_comb begin
    bus.m0_gnt    = 1'b0;
    bus.m0_rvalid = 1'b0;
    bus.m0_rdata  = '0;
    bus.m1_gnt    = 1'b0;
    bus.m1_rvalid = 1'b0;
    bus.m1_rdata  = '0;
    bus.s_req     = 1'b0;
    bus.s_we      = 1'b0;
    bus.s_addr    = '0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.bus_err   = 1'b0;
    if (reset) begin
      if (w_idle && w_any_req) begin
        bus.s_req = 1'b1;
        if (w_m1_win) begin
          bus.s_we    = bus.m1_we;
          bus.s_addr  = bus.m1_addr;
          bus.s_wdata = bus.m1_wdata;
          bus.s_wstrb = bus.m1_wstrb;
        end else begin
          bus.s_addr  = bus.m0_addr;
        end
        bus.m1_gnt = w_take && w_m1_win;
        bus.m0_gnt = w_take && !w_m1_win;
      end
      if (w_done) begin
        bus.bus_err = w_timeout;
        if (r_owner == OWN_LSU) begin
          bus.m1_rvalid = 1'b1;
          bus.m1_rdata  = w_rdata;
        end else begin
          bus.m0_rvalid = 1'b1;
          bus.m0_rdata  = w_rdata;
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
- Arbitrates the SoC's single memory/peripheral bus between two requesters: the core's instruction-fetch port (M0) and its load/store port (M1).
- Sits between the riscv32i core and the ROM/RAM/custom-peripheral decoder.
- Only one transaction may be outstanding at a time.
- Provides a starvation guard for M0 and a response timeout so a hung peripheral cannot freeze the pipeline.

Parameters:
- STARVE_LIM, 4: number of consecutive lost arbitrations by a requesting M0 before M0 is forced to win.
- TIMEOUT_CYC, 16: number of cycles to wait in WAIT for s_rvalid before an error response is returned.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m0_req  in  1  fetch request; held with m0_addr until m0_gnt.
- m0_addr  in  32  fetch address.
- m0_gnt  out  1  fetch address accepted (1-cycle pulse).
- m0_rvalid  out  1  fetch response valid (1-cycle pulse).
- m0_rdata  out  32  fetch data, valid with m0_rvalid.
- m1_req  in  1  load/store request; held with its fields until m1_gnt.
- m1_we  in  1  1 = store.
- m1_addr  in  32  data address.
- m1_wdata  in  32  store data.
- m1_wstrb  in  4  byte enables.
- m1_gnt  out  1  data request accepted.
- m1_rvalid  out  1  data response valid (loads and stores).
- m1_rdata  out  32  load data.
- s_req  out  1  bus request to slave.
- s_we  out  1  forwarded write enable.
- s_addr  out  32  forwarded address.
- s_wdata  out  32  forwarded write data.
- s_wstrb  out  4  forwarded byte enables.
- s_gnt  in  1  slave accepted address phase.
- s_rvalid  in  1  slave response valid.
- s_rdata  in  32  slave response data.
- bus_err  out  1  1-cycle pulse when a timeout occurs.

Behaviour:
- FSM has two states, IDLE and WAIT. Registered state: state, owner (0 = M0, 1 = M1), starve_cnt (3 bits), tmo_cnt (5 bits).
- Reset values:
  - state = IDLE, all counters = 0, owner = 0.
  - Every output is 0. s_* fields are driven 0 whenever s_req = 0.
- Arbitration (IDLE, combinational):
  - The winner is M1 if m1_req and not (m0_req and starve_cnt == STARVE_LIM); otherwise M0 if m0_req.
  - s_req = m0_req | m1_req, and s_* carry the winner's fields. For M0: s_we = 0, s_wstrb = 0, s_wdata = 0.
- Address phase (IDLE):
  - When s_req & s_gnt, the winner's mX_gnt = 1 in that same cycle.
  - On the next edge: owner <- winner, state <- WAIT, tmo_cnt <- 0.
  - If s_gnt = 0, stay in IDLE and re-arbitrate every cycle. A grant is not sticky.
- Starvation counter:
  - Increments (saturating at STARVE_LIM) on each IDLE cycle where m0_req = 1 and M1 is granted.
  - Clears when M0 is granted.
  - Holds otherwise, including when s_gnt = 0.
- WAIT state:
  - s_req = 0 and both gnt outputs are 0.
  - On s_rvalid: mX_rvalid(owner) = 1 and mX_rdata(owner) = s_rdata, combinationally in the same cycle (zero added latency). Next state is IDLE.
  - The non-owner's rvalid stays 0 and its rdata stays 0.
- Timeout:
  - In WAIT, tmo_cnt increments each cycle without s_rvalid.
  - When tmo_cnt == TIMEOUT_CYC-1 and s_rvalid = 0: owner rvalid = 1, rdata = ERR_DATA, bus_err = 1, next state IDLE.
  - If s_rvalid arrives in that same cycle, the real response wins and bus_err = 0.
- s_rvalid in IDLE (late response after a timeout, or after reset) is ignored and not forwarded.
- Throughput: at most one transaction per 2 cycles (grant, then response). The earliest next grant is the cycle after rvalid.
- Reset mid-transaction: FSM returns to IDLE asynchronously, the pending response is discarded, and counters clear.

Decomposition:
- soc_bus_pkg holds:
  - state encoding (ST_IDLE, ST_WAIT);
  - owner encoding (OWN_IF, OWN_LSU);
  - ERR_DATA default;
  - bus field widths (ADDR_W = 32, DATA_W = 32, STRB_W = 4).
- One sub-module, bus_sat_counter (parameterised width and limit, with clear/increment/saturate), instantiated for starve_cnt and tmo_cnt.

Test Plan:
- Single fetch:
  - Stimulus: m0_req, m0_addr = 0x0000_0004, s_gnt = 1 immediately, s_rvalid two cycles later with s_rdata = 0x0010_0093.
  - Required: m0_gnt pulses in cycle 0; m0_rvalid with 0x0010_0093; m1 outputs stay 0.
- Simultaneous requests:
  - Stimulus: m0 and m1 request in the same cycle; m1 is a store, addr 0x0000_0100, wdata 3, wstrb 4'hF.
  - Required: M1 is granted first with s_we = 1, s_wdata = 3; after m1_rvalid, M0 is granted on the following IDLE cycle.
- Starvation:
  - Stimulus: m0_req held while m1 re-requests continuously, slave latency 1.
  - Required: M1 wins 4 grants, the 5th grant goes to M0, and starve_cnt then reads 0.
- Timeout:
  - Stimulus: M1 load granted, slave never asserts s_rvalid.
  - Required: in the 16th WAIT cycle, m1_rvalid = 1, m1_rdata = 0xDEAD_BEEF, bus_err = 1 for one cycle; a later s_rvalid in IDLE produces no rvalid.
- Backpressure:
  - Stimulus: m0_req held, s_gnt = 0 for 3 cycles, then m1_req rises and s_gnt = 1.
  - Required: no m0_gnt during the stall; M1 wins when s_gnt rises; starve_cnt = 1.
- Reset mid-WAIT:
  - Stimulus: assert reset = 0 asynchronously two cycles after a grant, then release it.
  - Required: all outputs go 0 immediately; the slave's s_rvalid after release is ignored; a fresh m0 request is granted normally.
